// File: rtl/ascon_arbiter_if.sv
// Requester and engine-side signal bundle for the two-requester ASCON arbiter.
// The arbiter uses the slave modport; the requester/engine side uses master.
interface ascon_arbiter_if;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned NONCE_W = 128;
  localparam int unsigned AD_W    = 64;
  localparam int unsigned WAVE_W  = 1472;

  logic               req0_i;
  logic               req1_i;
  logic [KEY_W-1:0]   key0_i;
  logic [KEY_W-1:0]   key1_i;
  logic [NONCE_W-1:0] nonce0_i;
  logic [NONCE_W-1:0] nonce1_i;
  logic [AD_W-1:0]    ad0_i;
  logic [AD_W-1:0]    ad1_i;
  logic [WAVE_W-1:0]  wave0_i;
  logic [WAVE_W-1:0]  wave1_i;
  logic               end_tag_i;

  logic [KEY_W-1:0]   key_o;
  logic [NONCE_W-1:0] nonce_o;
  logic [AD_W-1:0]    ad_o;
  logic [WAVE_W-1:0]  wave_o;
  logic               start_ascon_o;
  logic               ascon_abort_o;
  logic [1:0]         grant_o;
  logic               busy_o;
  logic               done0_o;
  logic               done1_o;
  logic               err0_o;
  logic               err1_o;

  modport master (
    output req0_i, req1_i, key0_i, key1_i, nonce0_i, nonce1_i,
           ad0_i, ad1_i, wave0_i, wave1_i, end_tag_i,
    input  key_o, nonce_o, ad_o, wave_o, start_ascon_o, ascon_abort_o,
           grant_o, busy_o, done0_o, done1_o, err0_o, err1_o
  );

  modport slave (
    input  req0_i, req1_i, key0_i, key1_i, nonce0_i, nonce1_i,
           ad0_i, ad1_i, wave0_i, wave1_i, end_tag_i,
    output key_o, nonce_o, ad_o, wave_o, start_ascon_o, ascon_abort_o,
           grant_o, busy_o, done0_o, done1_o, err0_o, err1_o
  );
endinterface

// File: rtl/ascon_arbiter.sv
// Round-robin arbiter/sequencer sharing one ASCON-128 engine between two
// requesters: latches operands, starts the engine, waits for tag or timeout.
module ascon_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic            clock_i,
  input logic            reset_i,
  ascon_arbiter_if.slave bus
);
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned NONCE_W = 128;
  localparam int unsigned AD_W    = 64;
  localparam int unsigned WAVE_W  = 1472;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             pend0_q, pend0_d;
  logic             pend1_q, pend1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic             sel;

  logic [KEY_W-1:0]   key_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [AD_W-1:0]    ad_q;
  logic [WAVE_W-1:0]  wave_q;

  // Next-state and next-output decode; pulse outputs coincide with their state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pend0_d = pend0_q | bus.req0_i;
    pend1_d = pend1_q | bus.req1_i;
    start_d = 1'b0;
    abort_d = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    sel     = (pend0_q & pend1_q) ? ~last_q : pend1_q;

    case (state_q)
      ST_IDLE: begin
        if (pend0_q | pend1_q) begin
          state_d = ST_LATCH;
          owner_d = sel;
          last_d  = sel;
          if (sel) pend1_d = bus.req1_i;
          else     pend0_d = bus.req0_i;
        end
      end
      ST_LATCH: begin
        state_d = ST_START;
        start_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A tag on the terminal-count cycle still counts as success.
        if (bus.end_tag_i) begin
          state_d = ST_DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          err0_d  = ~owner_q;
          err1_d  = owner_q;
          abort_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    grant_d = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  // Control state and registered pulse/status outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      abort_q <= abort_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  // Operands load when leaving LATCH and then hold until the next operation.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      wave_q  <= '0;
    end else if (state_q == ST_LATCH) begin
      key_q   <= owner_q ? bus.key1_i   : bus.key0_i;
      nonce_q <= owner_q ? bus.nonce1_i : bus.nonce0_i;
      ad_q    <= owner_q ? bus.ad1_i    : bus.ad0_i;
      wave_q  <= owner_q ? bus.wave1_i  : bus.wave0_i;
    end
  end

  assign bus.key_o         = key_q;
  assign bus.nonce_o       = nonce_q;
  assign bus.ad_o          = ad_q;
  assign bus.wave_o        = wave_q;
  assign bus.start_ascon_o = start_q;
  assign bus.ascon_abort_o = abort_q;
  assign bus.grant_o       = grant_q;
  assign bus.busy_o        = busy_q;
  assign bus.done0_o       = done0_q;
  assign bus.done1_o       = done1_q;
  assign bus.err0_o        = err0_q;
  assign bus.err1_o        = err1_q;
endmodule
